a2d_arbiter: RTL
================

A2D_ARBITER -- requirements
Module: a2d_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 1023, sets the maximum WAIT-state cycles allowed before a conversion is abandoned.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req0  input  1  requester 0 (motion controller) conversion request, held high until vld0.
REQ-005 chnl0  input  3  requester 0 channel select, stable while req0 is high.
REQ-006 req1  input  1  requester 1 (battery/aux monitor) conversion request, held high until vld1.
REQ-007 chnl1  input  3  requester 1 channel select, stable while req1 is high.
REQ-008 strt_cnv  output  1  one-cycle start pulse to the A2D interface.
REQ-009 chnnl  output  3  channel presented to the A2D interface.
REQ-010 cnv_cmplt  input  1  A2D conversion-complete pulse.
REQ-011 A2D_res  input  12  A2D result, valid in the cycle cnv_cmplt is high.
REQ-012 res  output  12  registered result returned to the granted requester.
REQ-013 vld0 / vld1  output  1 each  one-cycle result-valid pulses for requester 0 / 1.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 timeout_err  output  1  sticky flag; set on any conversion timeout.

Function
REQ-016 The FSM shall have states IDLE, START, WAIT, DONE.
REQ-017 In IDLE with at least one req high, the FSM shall grant exactly one requester, latch its channel into chnnl, and go to START.
REQ-018 Arbitration shall be round-robin: on simultaneous req0 and req1, grant the requester not most recently served; after reset, requester 0 wins the first tie.
REQ-019 START shall last one cycle with strt_cnv=1, then go to WAIT; strt_cnv shall be 0 in every other state.
REQ-020 chnnl shall hold the granted channel from START through DONE inclusive.
REQ-021 In WAIT, cnv_cmplt=1 shall capture A2D_res into res and go to DONE.
REQ-022 DONE shall last one cycle, pulsing vld of the granted requester only, then go to IDLE and update the round-robin pointer.
REQ-023 Latency: a request sampled at edge N gives strt_cnv high in cycle N+1; cnv_cmplt sampled at edge M gives vld high in cycle M+1.
REQ-024 cnv_cmplt shall be ignored in IDLE, START and DONE.
REQ-025 A 10-bit wait counter shall clear on entering WAIT and increment each WAIT cycle.
REQ-026 If the wait counter reaches TIMEOUT without cnv_cmplt, the FSM shall load res=12'hFFF, set timeout_err, and go to DONE with the normal vld pulse.
REQ-027 If cnv_cmplt and the timeout occur in the same cycle, cnv_cmplt shall win and timeout_err shall not be set.
REQ-028 A req still high in the first IDLE cycle after DONE shall be treated as a new request.
REQ-029 A req withdrawn before grant shall be ignored; a req withdrawn after grant shall not abort the conversion, and vld shall still pulse.
REQ-030 Minimum spacing between consecutive strt_cnv pulses shall be 4 cycles: START, WAIT, DONE, IDLE.

Reset
REQ-031 rst high shall immediately force IDLE, strt_cnv=0, chnnl=0, res=0, vld0=vld1=0, busy=0, timeout_err=0, wait counter=0, and round-robin pointer to favour requester 0.
REQ-032 rst asserted mid-conversion shall discard the conversion with no vld pulse; a cnv_cmplt arriving after rst releases shall be ignored in IDLE.

Verification
REQ-033 Single request: req0=1, chnl0=3'd1; cnv_cmplt pulsed 50 cycles after strt_cnv with A2D_res=12'h020 -> strt_cnv 1 cycle after req; chnnl=1; vld0 one cycle later with res=12'h020; vld1 stays 0.
REQ-034 Tie then alternation: req0 and req1 both high from reset, chnl0=0, chnl1=4 -> grant order 0,1,0,1 with chnnl 0,4,0,4 and alternating vld0/vld1.
REQ-035 Back-to-back: req1 held continuously with immediate cnv_cmplt -> strt_cnv pulses exactly 4 cycles apart.
REQ-036 Timeout: req0=1, no cnv_cmplt -> after 1023 WAIT cycles, vld0 pulses with res=12'hFFF and timeout_err=1; timeout_err remains 1 through a later good conversion until rst.
REQ-037 Collision: cnv_cmplt arrives on the timeout cycle with A2D_res=12'h010 -> res=12'h010 and timeout_err=0.
REQ-038 Reset mid-WAIT: rst pulsed in WAIT, then cnv_cmplt pulsed -> no vld pulse, busy=0, all outputs at reset values.

Source files
------------

// File: rtl/a2d_arbiter_if.sv
// Requester / A2D-side signal bundle for the two-client A2D arbiter.
interface a2d_arbiter_if;
  logic        req0;
  logic [2:0]  chnl0;
  logic        req1;
  logic [2:0]  chnl1;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt;
  logic [11:0] A2D_res;
  logic [11:0] res;
  logic        vld0;
  logic        vld1;
  logic        busy;
  logic        timeout_err;

  // Environment side: requesters and the A2D converter.
  modport master (
    output req0, chnl0, req1, chnl1, cnv_cmplt, A2D_res,
    input  strt_cnv, chnnl, res, vld0, vld1, busy, timeout_err
  );

  // Arbiter side.
  modport slave (
    input  req0, chnl0, req1, chnl1, cnv_cmplt, A2D_res,
    output strt_cnv, chnnl, res, vld0, vld1, busy, timeout_err
  );
endinterface

// File: rtl/a2d_arbiter.sv
// Round-robin arbiter sharing one A2D converter between two requesters,
// with a conversion timeout that returns 12'hFFF and a sticky error flag.
module a2d_arbiter #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic          clk,
  input  logic          rst,
  a2d_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = 10;
  localparam int unsigned CH_W  = 3;
  localparam int unsigned RES_W = 12;
  // Counter value during the last allowed WAIT cycle (the TIMEOUT-th one).
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   wait_cnt;
  logic               last1;     // 1: requester 1 was served most recently
  logic               gnt;       // granted requester of the current conversion
  logic               strt_q;
  logic [CH_W-1:0]    chnnl_q;
  logic [RES_W-1:0]   res_q;
  logic               vld0_q;
  logic               vld1_q;
  logic               busy_q;
  logic               terr_q;
  logic               pick1;

  // Requester 1 wins when alone, or on a tie when requester 0 was served last.
  assign pick1 = bus.req1 & (~bus.req0 | ~last1);

  // Conversion sequencer with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      last1    <= 1'b1;
      gnt      <= 1'b0;
      strt_q   <= 1'b0;
      chnnl_q  <= '0;
      res_q    <= '0;
      vld0_q   <= 1'b0;
      vld1_q   <= 1'b0;
      busy_q   <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      strt_q <= 1'b0;
      vld0_q <= 1'b0;
      vld1_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req0 | bus.req1) begin
            gnt     <= pick1;
            chnnl_q <= pick1 ? bus.chnl1 : bus.chnl0;
            strt_q  <= 1'b1;
            busy_q  <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (bus.cnv_cmplt) begin
            res_q  <= bus.A2D_res;
            vld0_q <= ~gnt;
            vld1_q <= gnt;
            state  <= DONE;
          end else if (wait_cnt == TO_LAST) begin
            res_q  <= {RES_W{1'b1}};
            terr_q <= 1'b1;
            vld0_q <= ~gnt;
            vld1_q <= gnt;
            state  <= DONE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          last1  <= gnt;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.strt_cnv    = strt_q;
  assign bus.chnnl       = chnnl_q;
  assign bus.res         = res_q;
  assign bus.vld0        = vld0_q;
  assign bus.vld1        = vld1_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = terr_q;

endmodule
